// File: rtl/ps2_mouse_transmitter.sv
// ps2_mouse_transmitter
// Host-to-device half of the PS/2 mouse link. Sends one command byte with
// the host-request sequence, then checks the device acknowledge.
// The top level owns the open-drain buffers; this block only produces
// drive enables and the data value.
//
// Ports:
//   CLK, RESET         system clock, synchronous active-high reset
//   CLK_MOUSE_IN       PS/2 clock as seen at the pin
//   DATA_MOUSE_IN      PS/2 data as seen at the pin
//   CLK_MOUSE_OUT_EN   1 = pull PS/2 clock low
//   DATA_MOUSE_OUT     value driven on PS/2 data when enabled
//   DATA_MOUSE_OUT_EN  1 = drive PS/2 data
//   SEND_BYTE          send request, sampled only while idle
//   BYTE_TO_SEND       command byte, captured with SEND_BYTE
//   BUSY               high whenever not idle
//   BYTE_SENT          one-cycle pulse, byte sent and acknowledged
//   SEND_ERROR         one-cycle pulse, timeout or missing acknowledge
module ps2_mouse_transmitter #(
  parameter int CLK_HOLD_CYCLES    = 12000,
  parameter int DATA_SETUP_CYCLES  = 20,
  parameter int FIRST_EDGE_TIMEOUT = 1500000,
  parameter int BIT_TIMEOUT        = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic       SEND_ERROR
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLK_LOW   = 3'd1;
  localparam logic [2:0] S_DATA_LOW  = 3'd2;
  localparam logic [2:0] S_SEND_BITS = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // Terminal counts are stored as limit-1 so a counter sitting at the
  // terminal value means "the limit is reached on this edge".
  localparam logic [20:0] HOLD_LAST  = 21'(CLK_HOLD_CYCLES - 1);
  localparam logic [20:0] SETUP_LAST = 21'(DATA_SETUP_CYCLES - 1);
  localparam logic [20:0] FIRST_LAST = 21'(FIRST_EDGE_TIMEOUT - 1);
  localparam logic [20:0] BIT_LAST   = 21'(BIT_TIMEOUT - 1);

  logic [2:0]  state;
  logic [20:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  byte_q;
  logic        clk_prev;
  logic        fall;
  logic        timeout;
  logic [20:0] limit_last;

  assign fall = clk_prev & ~CLK_MOUSE_IN;
  assign BUSY = (state != S_IDLE);

  // The long first-edge window applies only until the device has produced
  // its first falling edge of the frame.
  always_comb begin
    limit_last = BIT_LAST;
    if (state == S_SEND_BITS && bit_cnt == 4'd0) limit_last = FIRST_LAST;
  end

  assign timeout = (cnt == limit_last);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state             <= S_IDLE;
      cnt               <= '0;
      bit_cnt           <= '0;
      byte_q            <= 8'h00;
      clk_prev          <= 1'b0;
      CLK_MOUSE_OUT_EN  <= 1'b0;
      DATA_MOUSE_OUT    <= 1'b0;
      DATA_MOUSE_OUT_EN <= 1'b0;
      BYTE_SENT         <= 1'b0;
      SEND_ERROR        <= 1'b0;
    end else begin
      clk_prev   <= CLK_MOUSE_IN;
      BYTE_SENT  <= 1'b0;
      SEND_ERROR <= 1'b0;
      case (state)
        S_IDLE: begin
          CLK_MOUSE_OUT_EN  <= 1'b0;
          DATA_MOUSE_OUT_EN <= 1'b0;
          DATA_MOUSE_OUT    <= 1'b0;
          cnt               <= '0;
          if (SEND_BYTE) begin
            byte_q           <= BYTE_TO_SEND;
            CLK_MOUSE_OUT_EN <= 1'b1;
            state            <= S_CLK_LOW;
          end
        end
        S_CLK_LOW: begin
          if (cnt == HOLD_LAST) begin
            cnt               <= '0;
            DATA_MOUSE_OUT_EN <= 1'b1;
            DATA_MOUSE_OUT    <= 1'b0;   // start bit
            state             <= S_DATA_LOW;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        S_DATA_LOW: begin
          if (cnt == SETUP_LAST) begin
            CLK_MOUSE_OUT_EN <= 1'b0;
            cnt              <= '0;
            bit_cnt          <= '0;
            state            <= S_SEND_BITS;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        S_SEND_BITS: begin
          if (timeout) begin
            DATA_MOUSE_OUT_EN <= 1'b0;
            SEND_ERROR        <= 1'b1;
            state             <= S_IDLE;
          end else if (fall) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8) begin
              DATA_MOUSE_OUT <= byte_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              DATA_MOUSE_OUT <= ~^byte_q;
            end else begin
              // stop bit: release and let the pull-up supply the 1
              DATA_MOUSE_OUT_EN <= 1'b0;
              state             <= S_WAIT_ACK;
            end
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        S_WAIT_ACK: begin
          if (timeout) begin
            SEND_ERROR <= 1'b1;
            state      <= S_IDLE;
          end else if (fall) begin
            cnt <= '0;
            if (!DATA_MOUSE_IN) begin
              state <= S_WAIT_IDLE;
            end else begin
              SEND_ERROR <= 1'b1;
              state      <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (timeout) begin
            SEND_ERROR <= 1'b1;
            state      <= S_IDLE;
          end else if (CLK_MOUSE_IN && DATA_MOUSE_IN) begin
            BYTE_SENT <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt + 21'd1;
          end
        end
        default: begin
          CLK_MOUSE_OUT_EN  <= 1'b0;
          DATA_MOUSE_OUT_EN <= 1'b0;
          state             <= S_IDLE;
        end
      endcase
    end
  end

endmodule
